// File: rtl/wm8731_dac_tx.sv
// WM8731 DAC I2S transmitter: divides clk into m_clk/b_clk/dac_lr_clk and serialises
// left/right sample pairs MSB first, one bit after each channel-clock edge.
module wm8731_dac_tx #(
  parameter int unsigned MCLK_HALF  = 2,
  parameter int unsigned BCLK_HALF  = 8,
  parameter int unsigned SLOT_BITS  = 32,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  m_clk,
  output logic                  b_clk,
  output logic                  dac_lr_clk,
  output logic                  dacdat,
  output logic                  underrun
);

  localparam int unsigned MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int unsigned BW = $clog2(2 * BCLK_HALF);
  localparam int unsigned IW = $clog2(2 * SLOT_BITS);

  localparam logic [MW-1:0] MC_LAST   = MW'(MCLK_HALF - 1);
  localparam logic [BW-1:0] BC_LAST   = BW'(2 * BCLK_HALF - 1);
  localparam logic [BW-1:0] BC_HIGH   = BW'(BCLK_HALF);
  localparam logic [IW-1:0] IDX_LAST  = IW'(2 * SLOT_BITS - 1);
  localparam logic [IW-1:0] IDX_RIGHT = IW'(SLOT_BITS);
  localparam logic [IW-1:0] L_LO      = IW'(1);
  localparam logic [IW-1:0] L_HI      = IW'(DATA_WIDTH);
  localparam logic [IW-1:0] R_LO      = IW'(SLOT_BITS + 1);
  localparam logic [IW-1:0] R_HI      = IW'(SLOT_BITS + DATA_WIDTH);

  logic [MW-1:0]         mc_q, mc_d;
  logic [BW-1:0]         bc_q, bc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  m_clk_q, m_clk_d;
  logic                  b_clk_q, b_clk_d;
  logic                  lr_q, lr_d;
  logic                  dacdat_q, dacdat_d;
  logic                  underrun_q, underrun_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic                  tick, frame_start, xfer;

  always_comb begin
    mc_d       = mc_q;
    m_clk_d    = m_clk_q;
    idx_d      = idx_q;
    lr_d       = lr_q;
    dacdat_d   = dacdat_q;
    underrun_d = 1'b0;
    full_d     = full_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;

    if (mc_q == MC_LAST) begin
      mc_d    = '0;
      m_clk_d = ~m_clk_q;
    end else begin
      mc_d = mc_q + 1'b1;
    end

    tick        = (bc_q == BC_LAST);
    bc_d        = tick ? '0 : bc_q + 1'b1;
    b_clk_d     = (bc_d >= BC_HIGH);
    frame_start = tick && (idx_q == IDX_LAST);

    xfer = in_valid && !full_q;
    if (xfer) begin
      hold_l_d = in_left;
      hold_r_d = in_right;
      full_d   = 1'b1;
    end

    // A sample arriving on an empty frame-start tick stays in holding (full_d set
    // above) while this frame is filled with zeros.
    if (tick) begin
      idx_d    = frame_start ? '0 : idx_q + 1'b1;
      lr_d     = (idx_d >= IDX_RIGHT);
      dacdat_d = 1'b0;
      if (frame_start) begin
        if (full_q) begin
          sh_l_d = hold_l_q;
          sh_r_d = hold_r_q;
          full_d = 1'b0;
        end else begin
          sh_l_d     = '0;
          sh_r_d     = '0;
          underrun_d = 1'b1;
        end
      end else if (idx_d >= L_LO && idx_d <= L_HI) begin
        dacdat_d = sh_l_q[DATA_WIDTH-1];
        sh_l_d   = sh_l_q << 1;
      end else if (idx_d >= R_LO && idx_d <= R_HI) begin
        dacdat_d = sh_r_q[DATA_WIDTH-1];
        sh_r_d   = sh_r_q << 1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mc_q       <= '0;
      bc_q       <= '0;
      idx_q      <= '0;
      m_clk_q    <= 1'b0;
      b_clk_q    <= 1'b0;
      lr_q       <= 1'b0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
    end else begin
      mc_q       <= mc_d;
      bc_q       <= bc_d;
      idx_q      <= idx_d;
      m_clk_q    <= m_clk_d;
      b_clk_q    <= b_clk_d;
      lr_q       <= lr_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
      full_q     <= full_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
    end
  end

  assign in_ready   = ~full_q;
  assign m_clk      = m_clk_q;
  assign b_clk      = b_clk_q;
  assign dac_lr_clk = lr_q;
  assign dacdat     = dacdat_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_wm8731_dac_tx.sv
// Bench for wm8731_dac_tx: directed stimulus pushes expected frames to a queue; a
// monitor captures dacdat on b_clk rising edges per frame and compares.
`timescale 1ns/1ps
module tb_wm8731_dac_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_left, in_right;
  logic        in_valid;
  logic        in_ready, m_clk, b_clk, dac_lr_clk, dacdat, underrun;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [63:0] exp_q[$];

  logic        mon_en = 1'b0;
  logic        lr_prev = 1'b0, b_prev = 1'b0, in_frame = 1'b0;
  int          bitn = 0;
  logic [63:0] cap;
  longint      lr_rise_t = -1;

  wm8731_dac_tx #(.MCLK_HALF(2), .BCLK_HALF(8), .SLOT_BITS(32), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .m_clk(m_clk), .b_clk(b_clk),
    .dac_lr_clk(dac_lr_clk), .dacdat(dacdat), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_frame(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] f;
    f = '0;
    for (int k = 1; k <= 16; k++) begin
      f[k]      = l[16-k];
      f[32 + k] = r[16-k];
    end
    return f;
  endfunction

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return m_clk;
      1:       return b_clk;
      default: return dac_lr_clk;
    endcase
  endfunction

  task automatic meas(input int sel, output longint per);
    logic   prev, cur;
    longint t0;
    per  = -1;
    t0   = -1;
    prev = sel_sig(sel);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      cur = sel_sig(sel);
      if (cur && !prev) begin
        if (t0 >= 0) begin
          per = longint'($time) - t0;
          break;
        end
        t0 = longint'($time);
      end
      prev = cur;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mclk"},     64'(m_clk),      64'd0);
    check({tag, "_bclk"},     64'(b_clk),      64'd0);
    check({tag, "_lrclk"},    64'(dac_lr_clk), 64'd0);
    check({tag, "_dacdat"},   64'(dacdat),     64'd0);
    check({tag, "_underrun"}, 64'(underrun),   64'd0);
    check({tag, "_in_ready"}, 64'(in_ready),   64'd1);
  endtask

  // Frame monitor: a frame starts where dac_lr_clk falls; bit k is sampled at the
  // k-th b_clk rise after that.
  always @(negedge clk) begin
    if (mon_en) begin
      if (lr_prev && !dac_lr_clk) begin
        in_frame = 1'b1;
        bitn     = 0;
        cap      = '0;
      end
      if (!lr_prev && dac_lr_clk) begin
        if (lr_rise_t >= 0) check("lr_period_ns", 64'(longint'($time) - lr_rise_t), 64'd10240);
        lr_rise_t = longint'($time);
      end
      if (in_frame && b_clk && !b_prev) begin
        cap[bitn] = dacdat;
        bitn++;
        if (bitn == 64) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            check("frame_unexpected", cap, 64'hXXXX_XXXX_XXXX_XXXX);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("frame_left_slot",  64'(cap[31:0]),  64'(e[31:0]));
            check("frame_right_slot", 64'(cap[63:32]), 64'(e[63:32]));
          end
        end
      end
      b_prev  = b_clk;
      lr_prev = dac_lr_clk;
    end
  end

  initial begin
    longint per;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    // Pre-run with a junk sample that reset must discard.
    reset    = 1'b0;
    in_valid = 1'b1;
    in_left  = 16'h1234;
    in_right = 16'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    wait_cyc(603);
    check("prerun_bclk_high", 64'(b_clk), 64'd1);
    check("prerun_lr_high",   64'(dac_lr_clk), 64'd1);
    check("prerun_full",      64'(in_ready), 64'd0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_hold");

    reset    = 1'b0;
    in_valid = 1'b1;
    in_left  = 16'hA5F0;
    in_right = 16'h0F3C;
    mon_en   = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("ready_after_xfer", 64'(in_ready), 64'd0);
        exp_q.push_back(mk_frame(16'hA5F0, 16'h0F3C));
        in_valid = 1'b0;
        check("mclk_edge1", 64'(m_clk), 64'd0);
      end
      if (n == 2)  check("mclk_edge2",  64'(m_clk), 64'd1);
      if (n == 7)  check("bclk_edge7",  64'(b_clk), 64'd0);
      if (n == 8)  check("bclk_edge8",  64'(b_clk), 64'd1);
      if (n == 15) check("bclk_edge15", 64'(b_clk), 64'd1);
      if (n == 16) check("bclk_edge16", 64'(b_clk), 64'd0);
    end
    meas(0, per);
    check("mclk_period_ns", 64'(per), 64'd40);
    meas(1, per);
    check("bclk_period_ns", 64'(per), 64'd160);

    // First frame start at edge 1024 consumes pair 1.
    wait_cyc(1023);
    check("pre_fs1_underrun", 64'(underrun), 64'd0);
    check("pre_fs1_lr",       64'(dac_lr_clk), 64'd1);
    @(negedge clk);
    check("fs1_underrun", 64'(underrun), 64'd0);
    check("fs1_ready",    64'(in_ready), 64'd1);
    check("fs1_lr",       64'(dac_lr_clk), 64'd0);
    exp_q.push_back(64'd0);

    // Nothing offered: frame start at 2048 underruns for one cycle.
    wait_cyc(2047);
    check("pre_fs2_underrun", 64'(underrun), 64'd0);
    @(negedge clk);
    check("fs2_underrun", 64'(underrun), 64'd1);
    @(negedge clk);
    check("fs2_underrun_end", 64'(underrun), 64'd0);

    // Backpressure: two pairs back to back.
    wait_cyc(2100);
    in_valid = 1'b1;
    in_left  = 16'h8001;
    in_right = 16'h7FFE;
    @(negedge clk);
    check("bp_ready_drop", 64'(in_ready), 64'd0);
    exp_q.push_back(mk_frame(16'h8001, 16'h7FFE));
    in_left  = 16'hFFFF;
    in_right = 16'h0001;
    exp_q.push_back(mk_frame(16'hFFFF, 16'h0001));
    @(negedge clk);
    check("bp_ready_wait", 64'(in_ready), 64'd0);
    wait_cyc(3071);
    check("bp_ready_before_fs", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("fs3_underrun", 64'(underrun), 64'd0);
    check("fs3_ready",    64'(in_ready), 64'd1);
    @(negedge clk);
    check("bp_second_xfer", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_cyc(4096);
    check("fs4_underrun", 64'(underrun), 64'd0);
    check("fs4_ready",    64'(in_ready), 64'd1);

    // Collision: pair offered exactly on the empty frame-start tick at 5120.
    wait_cyc(5119);
    in_valid = 1'b1;
    in_left  = 16'h3C5A;
    in_right = 16'hC3A5;
    @(negedge clk);
    check("col_underrun", 64'(underrun), 64'd1);
    check("col_ready",    64'(in_ready), 64'd0);
    in_valid = 1'b0;
    exp_q.push_back(64'd0);
    exp_q.push_back(mk_frame(16'h3C5A, 16'hC3A5));
    @(negedge clk);
    check("col_underrun_end", 64'(underrun), 64'd0);
    wait_cyc(6144);
    check("fs6_underrun", 64'(underrun), 64'd0);
    check("fs6_ready",    64'(in_ready), 64'd1);

    while (exp_q.size() != 0 && cyc < 8000) @(negedge clk);
    check("frames_pending", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wm8731_dac_tx.md
# wm8731_dac_tx

Serialising transmitter that drives the WM8731 DAC audio interface in I2S mode. It accepts parallel left/right samples over a valid/ready handshake and generates m_clk, b_clk, dac_lr_clk and dacdat from the system clock. It sits directly upstream of the codec pins and of the DAC-side functional monitor. That monitor measures the frequencies of these outputs, so all clock ratios are fixed here.

## Interface
- MCLK_HALF, 2: clk cycles per m_clk half-period (default clk/4).
- BCLK_HALF, 8: clk cycles per b_clk half-period (default clk/16).
- SLOT_BITS, 32: b_clk periods per channel slot. Frame length is 2*SLOT_BITS.
- DATA_WIDTH, 16: sample width. Requires DATA_WIDTH <= SLOT_BITS-1.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_left  in  DATA_WIDTH  left sample, two's complement, passed through unchanged.
- in_right  in  DATA_WIDTH  right sample.
- in_valid  in  1  sample pair offered.
- in_ready  out  1  holding register empty; transfer occurs on in_valid & in_ready.
- m_clk  out  1  codec master clock.
- b_clk  out  1  bit clock.
- dac_lr_clk  out  1  channel clock; 0 = left slot, 1 = right slot.
- dacdat  out  1  serial data, MSB first.
- underrun  out  1  one-cycle pulse when a frame starts with no sample pending.

## Operation
- m_clk divider: counter 0..MCLK_HALF-1; m_clk toggles on wrap. Free-running, independent of the data path.
- b_clk divider: bc counter 0..2*BCLK_HALF-1.
  - b_clk = 0 while bc < BCLK_HALF, otherwise 1.
  - A "falling tick" occurs on the clk edge where bc wraps to 0.
- Bit counter bit_idx 0..2*SLOT_BITS-1 advances on each falling tick and wraps to 0. The wrap is the frame-start tick.
- dac_lr_clk = (bit_idx >= SLOT_BITS). It changes only on falling ticks.
- Data slot layout (I2S, one-bit delay):
  - Left: bit_idx k in 1..DATA_WIDTH carries left[DATA_WIDTH-k].
  - Right: bit_idx SLOT_BITS+k carries right[DATA_WIDTH-k].
  - All other positions carry 0.
- dacdat is registered and updates only on falling ticks, so it is stable around every b_clk rising edge.
- Buffering: one holding register (left, right, full flag) plus a shift register pair.
  - in_ready = !full.
  - A handshake transfer loads holding and sets full.
- At the frame-start tick:
  - If full: holding moves into the shift registers and full clears.
  - If not full: the shift registers load zero, and underrun pulses high for exactly that clk cycle.
- Simultaneous handshake and frame-start tick while empty: counts as an underrun. The frame outputs zeros, and the new sample stays in holding for the next frame. There is no bypass.
- The frame immediately after reset outputs zeros. That frame's start is implicit, so it raises no underrun.

## Timing
- Reset (asynchronous) values:
  - m_clk, b_clk, dac_lr_clk, dacdat = 0.
  - underrun = 0; in_ready = 1.
  - All counters = 0; full = 0.
- Counting clk edges from the first rising edge after reset deasserts as edge 1:
  - m_clk rises at edge MCLK_HALF.
  - b_clk rises at edge BCLK_HALF; the first falling tick is at edge 2*BCLK_HALF.
  - The first frame-start tick is at edge 2*BCLK_HALF*2*SLOT_BITS (1024 with defaults).
- With the default parameters:
  - m_clk = clk/4, b_clk = clk/16, dac_lr_clk = clk/1024.
  - At 100 MHz this gives 25 MHz, 6.25 MHz and 97.656 kHz.
- Handshake to in_ready:
  - in_ready falls on the edge after a transfer.
  - It rises on the edge after the frame-start tick that consumes the sample.
- Worst-case latency from a sample being accepted to its MSB appearing on dacdat is one frame plus one b_clk period.
- Reset mid-frame: all outputs and counters return to their reset values immediately. Any pending sample is discarded, and the sequence restarts as from power-up.

## Test plan
- Reset: assert reset mid-frame, then check every output at its reset value while reset is high. After release, check b_clk rises at edge 8 and the first falling tick is at edge 16.
- Frequencies (defaults, clk period 10 ns): measure rising-to-rising periods of m_clk = 40 ns, b_clk = 160 ns and dac_lr_clk = 10240 ns.
- Data: offer left=16'hA5F0, right=16'h0F3C before the first frame start. Sample dacdat on b_clk rising edges.
  - Left slot bits 1..16 must read A5F0 MSB first; bits 0 and 17..31 must be 0.
  - The right slot must carry 0F3C in the same positions.
- Underrun: hold in_valid low through one frame start. Check underrun pulses for exactly one clk cycle at the tick, and dacdat stays 0 for the whole frame.
- Backpressure: offer two pairs back to back.
  - in_ready drops after the first transfer, and the second pair waits.
  - in_ready returns one cycle after the frame-start tick.
  - The frames carry pair 1 then pair 2, with no underrun.
- Collision: present a pair on the exact frame-start tick while holding is empty. Check underrun pulses, the current frame is zeros, and the pair is transmitted in the following frame.
